// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system ID block: request signals from
// the interconnect master and the registered read response.
interface nios_system_sysid_ext_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System ID slave: ID, timestamp, caps, scratch registers, and (when
// SYSID_UPTIME_EN is defined) a 64-bit uptime counter with HI snapshot and CONTROL.
module nios_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID   = 32'h5556_5A7A,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter logic [15:0] VERSION     = 16'h0001,
  parameter int          NUM_SCRATCH = 2,
  parameter int          ADDR_W      = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  nios_system_sysid_ext_if.slave bus
);

  localparam int NUM_SLOTS = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CAPS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SCR0 = ADDR_W'(6);

  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic [31:0]       r_scratch [NUM_SLOTS];
  logic [31:0]       w_rdata;
  logic              w_wr_en;
  logic              w_scr_sel;
  logic [ADDR_W-1:0] w_scr_off;
  logic              w_uptime_en;

  // A simultaneous read wins; the write in that cycle is dropped.
  assign w_wr_en   = bus.write & ~bus.read;
  assign w_scr_sel = (bus.address >= A_SCR0);
  assign w_scr_off = bus.address - A_SCR0;

`ifdef SYSID_UPTIME_EN
  localparam logic [ADDR_W-1:0] A_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(5);

  logic [63:0] r_uptime;
  logic [31:0] r_uptime_hi;
  logic        r_freeze;
  logic        w_ctrl_wr;
  logic        w_lo_rd;

  assign w_uptime_en = 1'b1;
  assign w_ctrl_wr   = w_wr_en & (bus.address == A_CTRL) & bus.byteenable[0];
  assign w_lo_rd     = bus.read & (bus.address == A_LO);

  // Uptime counter, freeze bit and HI snapshot; CLR beats freeze and increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uptime    <= 64'h0;
      r_uptime_hi <= 32'h0;
      r_freeze    <= 1'b0;
    end else begin
      if (w_ctrl_wr && bus.writedata[0]) begin
        r_uptime <= 64'h0;
      end else if (!r_freeze) begin
        r_uptime <= r_uptime + 64'h1;
      end
      if (w_ctrl_wr) begin
        r_freeze <= bus.writedata[1];
      end
      if (w_lo_rd) begin
        r_uptime_hi <= r_uptime[63:32];
      end
    end
  end
`else
  assign w_uptime_en = 1'b0;
`endif

  // Scratch registers with per-byte write enables.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_scratch[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr_en && w_scr_sel && (w_scr_off == ADDR_W'(i))) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) begin
              r_scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read data selection; anything not decoded returns zero.
  always_comb begin
    w_rdata = 32'h0;
    case (bus.address)
      A_ID:    w_rdata = SYSTEM_ID;
      A_TS:    w_rdata = TIMESTAMP;
      A_CAPS:  w_rdata = {VERSION, 8'(NUM_SCRATCH), 7'h00, w_uptime_en};
`ifdef SYSID_UPTIME_EN
      A_LO:    w_rdata = r_uptime[31:0];
      A_HI:    w_rdata = r_uptime_hi;
      A_CTRL:  w_rdata = {30'h0, r_freeze, 1'b0};
`endif
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (w_scr_sel && (w_scr_off == ADDR_W'(i))) begin
            w_rdata = r_scratch[i];
          end else begin
            w_rdata = w_rdata;
          end
        end
      end
    endcase
  end

  // Registered read response, one cycle after the strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.read;
      if (bus.read) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign bus.readdata      = r_rdata;
  assign bus.readdatavalid = r_rvalid;

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Self-checking bench for nios_system_sysid_ext; uptime checks follow SYSID_UPTIME_EN.
module tb_nios_system_sysid_ext;
  localparam int          ADDR_W = 3;
  localparam logic [31:0] SYSID  = 32'h5556_5A7A;
  localparam logic [31:0] ALL    = 32'hFFFF_FFFF;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS   = 32'h0001_0201;
`else
  localparam logic [31:0] CAPS   = 32'h0001_0200;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  nios_system_sysid_ext_if #(.ADDR_W(ADDR_W)) bus ();
  nios_system_sysid_ext_if #(.ADDR_W(ADDR_W)) bus1 ();

  nios_system_sysid_ext #(.NUM_SCRATCH(2), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  nios_system_sysid_ext #(.NUM_SCRATCH(1), .ADDR_W(ADDR_W)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.write = 1'b1; bus.address = a; bus.writedata = d; bus.byteenable = be;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [31:0] m);
    exp_t e;
    e.data = d; e.mask = m;
    exp_q.push_back(e);
    bus.read = 1'b1; bus.address = a;
    @(negedge clock);
    bus.read = 1'b0;
  endtask

  // Pops one expectation for every response seen on the main bus.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.readdatavalid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: readdata=%h with no read outstanding", bus.readdata);
        end else begin
          e = exp_q.pop_front();
          if ((bus.readdata & e.mask) !== (e.data & e.mask)) begin
            n_bad++;
            $display("FAIL read_data: got %h expected %h (mask %h)", bus.readdata, e.data, e.mask);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++;
    if (bus.readdatavalid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.readdatavalid);
    end
    n_vec++;
    if (bus.readdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", bus.readdata);
    end
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_back_to_back();
    bus_read(3'd0, SYSID, ALL);
    bus_read(3'd1, 32'h0, ALL);
    bus_read(3'd2, CAPS, ALL);
    idle(1);
    n_vec++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== CAPS) begin
      n_bad++;
      $display("FAIL hold_after_read: valid=%b data=%h expected valid=0 data=%h",
               bus.readdatavalid, bus.readdata, CAPS);
    end
  endtask

  task automatic test_scratch();
    bus_write(3'd6, 32'hDEAD_BEEF, 4'b0101);
    bus_read(3'd6, 32'h00AD_00EF, ALL);
    bus_read(3'd7, 32'h0, ALL);
    bus_write(3'd7, 32'h1357_9BDF, 4'hF);
    bus_read(3'd7, 32'h1357_9BDF, ALL);
    bus_read(3'd6, 32'h00AD_00EF, ALL);
    bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd0, SYSID, ALL);
    bus_write(3'd6, 32'hFFFF_FFFF, 4'b1000);
    bus_read(3'd6, 32'hFFAD_00EF, ALL);
  endtask

  task automatic test_scratch_single();
    bus1.write = 1'b1; bus1.address = 3'd6; bus1.writedata = 32'hA5A5_A5A5; bus1.byteenable = 4'hF;
    @(negedge clock);
    bus1.address = 3'd7; bus1.writedata = 32'hFFFF_FFFF;
    @(negedge clock);
    bus1.write = 1'b0; bus1.read = 1'b1; bus1.address = 3'd7;
    @(negedge clock);
    bus1.address = 3'd6;
    n_vec++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'h0) begin
      n_bad++; $display("FAIL single_slot7: valid=%b data=%h expected 1/00000000", bus1.readdatavalid, bus1.readdata);
    end
    @(negedge clock);
    bus1.read = 1'b0;
    n_vec++;
    if (bus1.readdatavalid !== 1'b1 || bus1.readdata !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL single_slot6: valid=%b data=%h expected 1/a5a5a5a5", bus1.readdatavalid, bus1.readdata);
    end
  endtask

  task automatic test_rw_collision();
    exp_t e;
    e.data = 32'hFFAD_00EF; e.mask = ALL;
    exp_q.push_back(e);
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 3'd6;
    bus.writedata = 32'h1234_5678; bus.byteenable = 4'hF;
    @(negedge clock);
    bus.read = 1'b0; bus.write = 1'b0;
    bus_read(3'd6, 32'hFFAD_00EF, ALL);
  endtask

`ifdef SYSID_UPTIME_EN
  task automatic test_uptime();
    bus_write(3'd5, 32'h1, 4'hF);
    idle(4);
    bus_read(3'd3, 32'd4, ALL);
    bus_read(3'd4, 32'd0, ALL);
    bus_write(3'd5, 32'h3, 4'hF);
    bus_read(3'd3, 32'd0, ALL);
    idle(10);
    bus_read(3'd3, 32'd0, ALL);
    bus_read(3'd5, 32'h2, ALL);
    bus_write(3'd5, 32'h0, 4'b1110);
    idle(3);
    bus_read(3'd3, 32'd0, ALL);
    bus_read(3'd5, 32'h2, ALL);
  endtask

  task automatic test_snapshot();
    bus_write(3'd5, 32'h0, 4'hF);
    force dut.r_uptime = 64'h0000_0001_FFFF_FFFF;
    bus_read(3'd3, 32'hFFFF_FFFF, ALL);
    release dut.r_uptime;
    idle(3);
    bus_read(3'd4, 32'h0000_0001, ALL);
    bus_read(3'd3, 32'h0, 32'h0);
    bus_read(3'd4, 32'h0000_0002, ALL);
    bus_write(3'd5, 32'h3, 4'hF);
    bus_read(3'd4, 32'h0000_0002, ALL);
    bus_read(3'd3, 32'h0, ALL);
    bus_read(3'd4, 32'h0, ALL);
  endtask
`else
  task automatic test_no_uptime();
    bus_write(3'd5, 32'h2, 4'hF);
    bus_write(3'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd2, 32'h0001_0200, ALL);
    bus_read(3'd3, 32'h0, ALL);
    bus_read(3'd4, 32'h0, ALL);
    bus_read(3'd5, 32'h0, ALL);
  endtask
`endif

  task automatic test_reset_abort();
    bus.read = 1'b1; bus.address = 3'd6;
    #2 reset_n = 1'b0;
    @(negedge clock);
    bus.read = 1'b0;
    n_vec++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      n_bad++; $display("FAIL abort_before_edge: valid=%b data=%h expected 0/0", bus.readdatavalid, bus.readdata);
    end
    reset_n = 1'b1;
    bus_write(3'd6, 32'h0BAD_F00D, 4'hF);
    bus.read = 1'b1; bus.address = 3'd6;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      n_bad++; $display("FAIL abort_async: valid=%b data=%h expected 0/0", bus.readdatavalid, bus.readdata);
    end
    bus.read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    bus_read(3'd6, 32'h0, ALL);
    bus_read(3'd2, CAPS, ALL);
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = 32'h0; bus.byteenable = 4'h0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0; bus1.writedata = 32'h0; bus1.byteenable = 4'h0;
    fork
      monitor();
    join_none
    test_reset();
    test_back_to_back();
    test_scratch();
    test_scratch_single();
    test_rw_collision();
`ifdef SYSID_UPTIME_EN
    test_uptime();
    test_snapshot();
`else
    test_no_uptime();
`endif
    test_reset_abort();
    idle(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL missing_responses: %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
